sme_feeder: RTL and testbench
=============================

SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset, input, 1, asynchronous, active-low; asserting it (low) clears all state immediately.
REQ-003 SHALL have ports: in_valid, input, 1, upstream byte valid.
REQ-004 SHALL have ports: in_ready, output, 1, feeder accepts a byte this cycle.
REQ-005 SHALL have ports: in_data, input, 8, ASCII character.
REQ-006 SHALL have ports: in_is_pat, input, 1, 0 = string record byte, 1 = pattern record byte.
REQ-007 SHALL have ports: in_last, input, 1, final byte of the current record.
REQ-008 SHALL have ports: chardata, output, 8, character to the matcher.
REQ-009 SHALL have ports: isstring, output, 1, string burst strobe to the matcher.
REQ-010 SHALL have ports: ispattern, output, 1, pattern burst strobe to the matcher.
REQ-011 SHALL have ports: valid, input, 1, matcher result pulse.
REQ-012 SHALL have ports: match, input, 1, matcher hit.
REQ-013 SHALL have ports: match_index, input, 5, matcher hit position.
REQ-014 SHALL have ports: res_valid, output, 1, result held.
REQ-015 SHALL have ports: res_ready, input, 1, downstream consumes result.
REQ-016 SHALL have ports: res_match, output, 1, captured match.
REQ-017 SHALL have ports: res_index, output, 5, captured match_index.
REQ-018 SHALL have ports: res_err, output, 1, 1 = record rejected or watchdog expiry; res_match=0, res_index=0.

Function
REQ-019 SHALL use FSM states IDLE, LOAD_S, LOAD_P, SEND_S, SEND_P, WAIT_RES, HOLD.
REQ-020 SHALL accept a byte when in_valid && in_ready; in_ready=1 only in IDLE, LOAD_S and LOAD_P.
REQ-021 SHALL transition IDLE->LOAD_S on accepted byte with in_is_pat=0, IDLE->LOAD_P on in_is_pat=1; the first byte is stored.
REQ-022 SHALL store string bytes into a 32x8 buffer with a 6-bit length counter; bytes beyond 32 are dropped and flag the record as error.
REQ-023 SHALL store pattern bytes into an 8x8 buffer with a 4-bit length counter; bytes beyond 8 are dropped and flag the record as error.
REQ-024 SHALL move from LOAD_S on in_last to LOAD_P, accepting only in_is_pat=1 bytes there; an in_is_pat=0 byte in LOAD_P flags error.
REQ-025 SHALL move from LOAD_P on in_last to SEND_S if a new string was loaded, or to SEND_P if reusing the previously sent string.
REQ-026 SHALL treat a pattern-only record when no string has been sent since reset, or any flagged record, as follows: skip sending and go to HOLD with res_err=1.
REQ-027 SHALL hold isstring=1 in SEND_S for exactly string-length consecutive cycles with chardata=buffer[0..len-1].
REQ-028 SHALL raise ispattern=1 in the cycle immediately following the last isstring cycle, with no gap, for exactly pattern-length cycles.
REQ-029 SHALL keep isstring, ispattern and chardata 0 outside SEND_S and SEND_P; isstring and ispattern are never both 1.
REQ-030 SHALL, in WAIT_RES, capture match and match_index on valid=1, then go to HOLD.
REQ-031 SHALL run an 8-bit watchdog in WAIT_RES; at 255 cycles without valid, go to HOLD with res_err=1.
REQ-032 SHALL hold res_valid=1 in HOLD until res_ready, then return to IDLE; no new record is accepted while in HOLD.
REQ-033 SHALL ignore a valid pulse outside WAIT_RES.

Reset
REQ-034 SHALL on reset (low) set the FSM to IDLE, drive in_ready=0 for that cycle, and clear all outputs, counters, watchdog, both buffers (0x00) and the string-loaded flag.
REQ-035 SHALL treat reset mid-burst as an abort: strobes drop to 0 asynchronously and no result is produced.

Structure
REQ-036 SHALL place in shared package sme_pkg: the FSM state enum, STR_MAX=32, PAT_MAX=8, WDOG_MAX=255, and character constants 0x5E, 0x24, 0x2E, 0x2A, 0x20.
REQ-037 SHALL implement both buffers from one parameterised sub-module sme_char_buf (DEPTH, write port, read port).

Verification
REQ-038 SHALL be verified with: string "abcd" + pattern "bc" -> isstring 4 cycles, then ispattern 2 cycles with no gap; valid with match=1, index=1 gives res_valid, res_match=1, res_index=1.
REQ-039 SHALL be verified with: pattern-only "^a" after the above -> no isstring, ispattern 2 cycles, string reused.
REQ-040 SHALL be verified with: pattern-only record immediately after reset -> no strobes; res_valid=1, res_err=1.
REQ-041 SHALL be verified with: 33-byte string record -> res_err=1, no strobes; 9-byte pattern likewise.
REQ-042 SHALL be verified with: valid never returned -> res_err=1 after 255 WAIT_RES cycles; res_ready held 0 for 10 cycles -> res_valid held, in_ready=0.
REQ-043 SHALL be verified with: reset asserted at 3rd isstring cycle -> strobes 0 immediately, FSM in IDLE, res_valid=0.

Source files
------------

// File: rtl/sme_pkg.sv
// sme_pkg: shared types and constants for the string-match feeder.
`default_nettype none

package sme_pkg;

    localparam int STR_MAX  = 32;
    localparam int PAT_MAX  = 8;
    localparam int WDOG_MAX = 255;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_S   = 3'd1,
        LOAD_P   = 3'd2,
        SEND_S   = 3'd3,
        SEND_P   = 3'd4,
        WAIT_RES = 3'd5,
        HOLD     = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sme_char_buf.sv
// sme_char_buf: byte-wide register buffer, one synchronous write port and
// one combinational read port, cleared by the asynchronous reset.
`default_nettype none

module sme_char_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sme_feeder.sv
// sme_feeder: buffers string/pattern records, replays them as isstring then
// ispattern bursts to the matcher, and holds the matcher's result.
`default_nettype none

module sme_feeder
    import sme_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_is_pat,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_err
);

    localparam logic [5:0] STR_FULL  = 6'(STR_MAX);
    localparam logic [3:0] PAT_FULL  = 4'(PAT_MAX);
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_MAX - 1);

    state_t     state, state_nx;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic [5:0] send_idx;
    logic [7:0] wdog;
    logic       rec_err;
    logic       str_new;
    logic       str_loaded;
    logic       res_match_q;
    logic [4:0] res_index_q;
    logic       res_err_q;

    logic       accept;
    logic       is_str_byte, is_pat_byte, bad_kind;
    logic [5:0] str_cnt;
    logic [3:0] pat_cnt;
    logic       str_ovf, pat_ovf, str_wr, pat_wr;
    logic       err_now, str_new_now;
    state_t     end_target;
    logic [7:0] str_rd, pat_rd;

    // Byte classification for the load phase; in IDLE a record restarts at 0.
    assign accept      = in_valid && in_ready;
    assign is_str_byte = accept && !in_is_pat && (state == IDLE || state == LOAD_S);
    assign is_pat_byte = accept &&  in_is_pat && (state == IDLE || state == LOAD_P);
    assign bad_kind    = accept && ((state == LOAD_S &&  in_is_pat) ||
                                    (state == LOAD_P && !in_is_pat));
    assign str_cnt     = (state == LOAD_S) ? str_len : 6'd0;
    assign pat_cnt     = (state == LOAD_P) ? pat_len : 4'd0;
    assign str_ovf     = is_str_byte && (str_cnt == STR_FULL);
    assign pat_ovf     = is_pat_byte && (pat_cnt == PAT_FULL);
    assign str_wr      = is_str_byte && !str_ovf;
    assign pat_wr      = is_pat_byte && !pat_ovf;
    assign err_now     = ((state != IDLE) && rec_err) || bad_kind || str_ovf || pat_ovf;
    assign str_new_now = (state == IDLE) ? !in_is_pat : str_new;

    // Where a completed record goes: rejected, fresh string, or reused string.
    always_comb begin
        end_target = HOLD;
        if (!err_now && (str_new_now || str_loaded)) begin
            end_target = str_new_now ? SEND_S : SEND_P;
        end
    end

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (str_wr),
        .wr_addr (str_cnt[4:0]),
        .wr_data (in_data),
        .rd_addr (send_idx[4:0]),
        .rd_data (str_rd)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pat_wr),
        .wr_addr (pat_cnt[2:0]),
        .wr_data (in_data),
        .rd_addr (send_idx[2:0]),
        .rd_data (pat_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_is_pat) begin
                        state_nx = in_last ? end_target : LOAD_P;
                    end else begin
                        state_nx = in_last ? LOAD_P : LOAD_S;
                    end
                end
            end
            LOAD_S: begin
                if (accept && in_last) begin
                    state_nx = LOAD_P;
                end
            end
            LOAD_P: begin
                if (accept && in_last) begin
                    state_nx = end_target;
                end
            end
            SEND_S: begin
                if (send_idx == str_len - 6'd1) begin
                    state_nx = SEND_P;
                end
            end
            SEND_P: begin
                if (send_idx == {2'b00, pat_len} - 6'd1) begin
                    state_nx = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (valid || wdog == WDOG_LAST) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gating with reset makes the strobes fall the moment reset asserts.
    always_comb begin
        in_ready  = 1'b0;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
        res_valid = 1'b0;
        if (reset) begin
            in_ready  = (state == IDLE) || (state == LOAD_S) || (state == LOAD_P);
            isstring  = (state == SEND_S);
            ispattern = (state == SEND_P);
            res_valid = (state == HOLD);
            if (state == SEND_S) begin
                chardata = str_rd;
            end else if (state == SEND_P) begin
                chardata = pat_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_len     <= 6'd0;
            pat_len     <= 4'd0;
            send_idx    <= 6'd0;
            wdog        <= 8'd0;
            rec_err     <= 1'b0;
            str_new     <= 1'b0;
            str_loaded  <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= 5'd0;
            res_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                rec_err <= err_now;
                str_new <= str_new_now;
            end
            // A new string overwrites the buffer, so the old one is no longer reusable.
            if (is_str_byte && state == IDLE) begin
                str_loaded <= 1'b0;
                pat_len    <= 4'd0;
            end else if (state == SEND_S) begin
                str_loaded <= 1'b1;
            end
            if (str_wr) begin
                str_len <= str_cnt + 6'd1;
            end
            if (pat_wr) begin
                pat_len <= pat_cnt + 4'd1;
            end

            if (state == SEND_S && state_nx == SEND_P) begin
                send_idx <= 6'd0;
            end else if (state == SEND_S || state == SEND_P) begin
                send_idx <= send_idx + 6'd1;
            end else begin
                send_idx <= 6'd0;
            end

            wdog <= (state == WAIT_RES && !valid) ? wdog + 8'd1 : 8'd0;

            if (state_nx == HOLD && state != HOLD) begin
                if (state == WAIT_RES && valid) begin
                    res_match_q <= match;
                    res_index_q <= match_index;
                    res_err_q   <= 1'b0;
                end else begin
                    res_match_q <= 1'b0;
                    res_index_q <= 5'd0;
                    res_err_q   <= 1'b1;
                end
            end else if (state == HOLD && res_ready) begin
                res_match_q <= 1'b0;
                res_index_q <= 5'd0;
                res_err_q   <= 1'b0;
            end
        end
    end

    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign res_err   = res_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed scenario tests for sme_feeder.
`default_nettype none

module tb_sme_feeder;
    import sme_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_is_pat = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid = 1'b0;
    logic       match = 1'b0;
    logic [4:0] match_index = 5'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mon_chars[$];
    int         mon_ns, mon_np;
    bit         mon_bad, mon_timeout;

    sme_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_is_pat   (in_is_pat),
        .in_last     (in_last),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_match   (res_match),
        .res_index   (res_index),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout got 1 want 0");
        $fatal(1, "simulation time limit reached");
    end

    // Streams string bytes then pattern bytes, one per cycle; starts and ends on a negedge.
    task automatic send_record(input string s, input string p);
        int ns = s.len();
        int np = p.len();
        for (int i = 0; i < ns + np; i++) begin
            in_valid = 1'b1;
            if (i < ns) begin
                in_data   = s[i];
                in_is_pat = 1'b0;
                in_last   = (i == ns - 1);
            end else begin
                in_data   = p[i - ns];
                in_is_pat = 1'b1;
                in_last   = (i == ns + np - 1);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_load byte %0d got %b want 1", i, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_is_pat = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
    endtask

    // Records strobes/characters until the burst ends or a result appears.
    task automatic monitor_burst();
        bit started = 0;
        bit done = 0;
        mon_chars.delete();
        mon_ns = 0;
        mon_np = 0;
        mon_bad = 0;
        mon_timeout = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (isstring && ispattern) mon_bad = 1;
            if (isstring || ispattern) begin
                started = 1;
                if (isstring) mon_ns++;
                if (ispattern) mon_np++;
                if (isstring && mon_np != 0) mon_bad = 1;
                mon_chars.push_back(chardata);
            end else begin
                if (chardata !== 8'h00) mon_bad = 1;
                if (started || res_valid) done = 1;
            end
            if (!done) @(negedge clk);
        end
        if (!done) mon_timeout = 1;
    endtask

    function automatic bit chars_equal(input string exp);
        if (mon_chars.size() != exp.len()) return 0;
        for (int i = 0; i < exp.len(); i++) begin
            if (mon_chars[i] !== exp[i]) return 0;
        end
        return 1;
    endfunction

    task automatic pop_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic return_result(input logic m, input logic [4:0] idx);
        valid       = 1'b1;
        match       = m;
        match_index = idx;
        @(negedge clk);
        valid       = 1'b0;
        match       = 1'b0;
        match_index = 5'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, isstring, ispattern, res_valid, chardata} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000",
                     {in_ready, isstring, ispattern, res_valid, chardata});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_pattern_only_after_reset();
        string p;
        p = {CH_CARET, "a"};
        send_record("", p);
        monitor_burst();
        checks++;
        if (mon_ns != 0 || mon_np != 0 || mon_timeout) begin
            errors++;
            $display("FAIL patonly_rst_strobes got s%0d p%0d to%0d want s0 p0 to0",
                     mon_ns, mon_np, mon_timeout);
        end
        checks++;
        if ({res_valid, res_err, res_match, res_index} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL patonly_rst_result got %b want 11000000",
                     {res_valid, res_err, res_match, res_index});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_ready got %b want 0", in_ready);
        end
        pop_result();
    endtask

    task automatic test_basic();
        send_record("abcd", "bc");
        monitor_burst();
        checks++;
        if (mon_ns != 4 || mon_np != 2 || mon_bad || mon_timeout) begin
            errors++;
            $display("FAIL basic_strobes got s%0d p%0d bad%0d to%0d want s4 p2 bad0 to0",
                     mon_ns, mon_np, mon_bad, mon_timeout);
        end
        checks++;
        if (!chars_equal("abcdbc")) begin
            errors++;
            $display("FAIL basic_chars got %0d chars want abcdbc", mon_chars.size());
        end
        return_result(1'b1, 5'd1);
        checks++;
        if ({res_valid, res_match, res_index, res_err} !== 8'b1100_0010) begin
            errors++;
            $display("FAIL basic_result got %b want 11000010",
                     {res_valid, res_match, res_index, res_err});
        end
        pop_result();
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release got v%b r%b want v0 r1", res_valid, in_ready);
        end
    endtask

    task automatic test_reuse();
        // A stray result pulse while idle must not be captured.
        return_result(1'b1, 5'd7);
        send_record("", "^a");
        monitor_burst();
        checks++;
        if (mon_ns != 0 || mon_np != 2 || mon_bad || mon_timeout) begin
            errors++;
            $display("FAIL reuse_strobes got s%0d p%0d bad%0d to%0d want s0 p2 bad0 to0",
                     mon_ns, mon_np, mon_bad, mon_timeout);
        end
        checks++;
        if (!chars_equal("^a")) begin
            errors++;
            $display("FAIL reuse_chars got %0d chars want ^a", mon_chars.size());
        end
        return_result(1'b0, 5'd0);
        checks++;
        if ({res_valid, res_match, res_index, res_err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reuse_result got %b want 10000000",
                     {res_valid, res_match, res_index, res_err});
        end
        pop_result();
    endtask

    task automatic test_overflow();
        string s33, s32, p9, p8;
        s33 = ""; s32 = ""; p9 = ""; p8 = "";
        for (int i = 0; i < 33; i++) s33 = {s33, "a"};
        for (int i = 0; i < 31; i++) s32 = {s32, "k"};
        s32 = {s32, "z"};
        for (int i = 0; i < 9; i++) p9 = {p9, "p"};
        p8 = "1234567q";

        send_record(s33, "x");
        monitor_burst();
        checks++;
        if (mon_ns != 0 || mon_np != 0 || !res_valid || res_err !== 1'b1) begin
            errors++;
            $display("FAIL str_ovf got s%0d p%0d v%b e%b want s0 p0 v1 e1",
                     mon_ns, mon_np, res_valid, res_err);
        end
        pop_result();

        send_record("ab", p9);
        monitor_burst();
        checks++;
        if (mon_ns != 0 || mon_np != 0 || !res_valid || res_err !== 1'b1) begin
            errors++;
            $display("FAIL pat_ovf got s%0d p%0d v%b e%b want s0 p0 v1 e1",
                     mon_ns, mon_np, res_valid, res_err);
        end
        pop_result();

        send_record(s32, p8);
        monitor_burst();
        checks++;
        if (mon_ns != 32 || mon_np != 8 || mon_bad || mon_timeout) begin
            errors++;
            $display("FAIL full_strobes got s%0d p%0d bad%0d to%0d want s32 p8 bad0 to0",
                     mon_ns, mon_np, mon_bad, mon_timeout);
        end
        checks++;
        if (!chars_equal({s32, p8})) begin
            errors++;
            $display("FAIL full_chars got %0d chars want 40 matching", mon_chars.size());
        end
        return_result(1'b1, 5'd31);
        checks++;
        if ({res_valid, res_match, res_index, res_err} !== 8'b1111_1110) begin
            errors++;
            $display("FAIL full_result got %b want 11111110",
                     {res_valid, res_match, res_index, res_err});
        end
        pop_result();
    endtask

    task automatic test_watchdog();
        int waits = 0;
        bit hold_bad = 0;
        send_record("ab", "a");
        monitor_burst();
        checks++;
        if (mon_ns != 2 || mon_np != 1 || mon_timeout) begin
            errors++;
            $display("FAIL wdog_strobes got s%0d p%0d to%0d want s2 p1 to0",
                     mon_ns, mon_np, mon_timeout);
        end
        while (!res_valid && waits < 400) begin
            waits++;
            @(negedge clk);
        end
        checks++;
        if (waits != 255) begin
            errors++;
            $display("FAIL wdog_cycles got %0d want 255", waits);
        end
        checks++;
        if ({res_valid, res_err, res_match, res_index} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL wdog_result got %b want 11000000",
                     {res_valid, res_err, res_match, res_index});
        end
        in_valid  = 1'b1;
        in_is_pat = 1'b1;
        in_last   = 1'b1;
        in_data   = "q";
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_err !== 1'b1) hold_bad = 1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_is_pat = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL hold_stall got 1 want 0 (res_valid/in_ready/res_err drifted)");
        end
        pop_result();
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wdog_release got v%b r%b want v0 r1", res_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        bit quiet_bad = 0;
        send_record("abcdef", "x");
        for (int c = 0; c < 10; c++) begin
            if (isstring) n++;
            if (n == 3) break;
            @(negedge clk);
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL midrst_reach got %0d want 3", n);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({isstring, ispattern, res_valid, in_ready, chardata} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_async got %h want 000",
                     {isstring, ispattern, res_valid, in_ready, chardata});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got r%b v%b want r1 v0", in_ready, res_valid);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (isstring || ispattern || res_valid) quiet_bad = 1;
        end
        checks++;
        if (quiet_bad) begin
            errors++;
            $display("FAIL midrst_quiet got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_pattern_only_after_reset();
        test_basic();
        test_reuse();
        test_overflow();
        test_watchdog();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
